// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode constants, datapath select encodings and the per-state control decode.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMMSH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
  } ctrl_t;

  // States whose exit waits on mem_ready and is guarded by the timeout counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  // Pure state decode; the FETCH ir_write/pc_write pulse depends on mem_ready
  // and is added by the controller itself.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: c.alu_src_b = SRCB_IMMSH2;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
      end
      S_ADDIWB: c.reg_we = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mem_wait.sv
// Memory wait counter: counts stalled cycles in a wait state and flags a
// timeout on the stalled cycle that would bring the count to MEM_TIMEOUT.
module mips_mem_wait #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_count;
  logic       w_stall;

  assign w_stall   = i_wait && !i_mem_ready;
  assign o_timeout = w_stall && (r_count == LIMIT);

  // Any exit (success, timeout, or not waiting) clears, so every entry starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_stall && !o_timeout) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= '0;
    end
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// with memory-ready handshaking, timeout and sticky error flags.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  state_t r_state;
  logic   r_illegal_op;
  logic   r_bus_err;
  logic   w_timeout;
  logic   w_fetch_done;
  ctrl_t  w_ctrl;

  mips_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .rst        (rst),
    .i_wait     (is_wait_state(r_state)),
    .i_mem_ready(mem_ready),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
      r_bus_err    <= 1'b0;
    end else if (w_timeout) begin
      r_state   <= S_FETCH;
      r_bus_err <= 1'b1;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_state      <= S_FETCH;
              r_illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  r_state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  r_state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // rst gating keeps the fetch pulse quiet while reset holds the FSM in FETCH.
  assign w_fetch_done = (r_state == S_FETCH) && mem_ready && rst;
  assign w_ctrl       = state_ctrl(r_state);

  assign pc_write      = w_ctrl.pc_write | w_fetch_done;
  assign ir_write      = w_fetch_done;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign reg_we        = w_ctrl.reg_we;
  assign reg_dst       = w_ctrl.reg_dst;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = r_illegal_op;
  assign bus_err       = r_bus_err;
  assign state_dbg     = r_state;

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum number of cycles to wait for mem_ready (range 1-255).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port opcode, input, 6, instruction-register bits [31:26].
REQ-005 SHALL have port mem_ready, input, 1, memory access complete; sampled only in memory states.
REQ-006 SHALL have port pc_write / pc_write_cond, output, 1 each, unconditional / branch-conditional PC load.
REQ-007 SHALL have port i_or_d, output, 1, memory address select: 0=PC, 1=ALUOut.
REQ-008 SHALL have port mem_read / mem_write, output, 1 each, memory strobes.
REQ-009 SHALL have port ir_write, output, 1, instruction-register load.
REQ-010 SHALL have port reg_we, output, 1, register-file write enable; the file captures on the negedge inside the asserted cycle.
REQ-011 SHALL have port reg_dst / mem_to_reg, output, 1 each, destination select (0=rt, 1=rd) / write-data select (0=ALUOut, 1=MDR).
REQ-012 SHALL have port alu_src_a, output, 1, 0=PC, 1=A.
REQ-013 SHALL have port alu_src_b, output, 2, 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2.
REQ-014 SHALL have port alu_op, output, 2, 00=add, 01=sub, 10=use funct.
REQ-015 SHALL have port pc_source, output, 2, 00=ALU result, 01=ALUOut, 10=jump target.
REQ-016 SHALL have port illegal_op / bus_err, output, 1 each, sticky error flags.
REQ-017 SHALL have port state_dbg, output, 4, current state encoding.

Function
REQ-018 SHALL be a Moore FSM; every control output SHALL be a function of the current state only; unlisted outputs SHALL be 0.
REQ-019 SHALL have state FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. It SHALL hold until mem_ready=1; in that cycle ir_write=1 and pc_write=1, then go to DECODE.
REQ-020 SHALL have state DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00, so the branch target goes to ALUOut; the register file registers A/B at the closing edge.
REQ-021 SHALL dispatch from DECODE on opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other value -> FETCH with illegal_op set.
REQ-022 SHALL have state MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next state SHALL be MEMRD for lw and MEMWR for sw.
REQ-023 SHALL have state MEMRD (3): mem_read=1, i_or_d=1. It SHALL wait for mem_ready, then go to MEMWB.
REQ-024 SHALL have state MEMWB (4): reg_we=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-025 SHALL have state MEMWR (5): mem_write=1, i_or_d=1. It SHALL wait for mem_ready, then go to FETCH.
REQ-026 SHALL have state EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB.
REQ-027 SHALL have state ALUWB (7): reg_we=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-028 SHALL have state BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-029 SHALL have states ADDIEX (9) (as MEMADR) and ADDIWB (10) (reg_we=1, reg_dst=0, mem_to_reg=0); ADDIEX SHALL go to ADDIWB, then ADDIWB to FETCH.
REQ-030 SHALL have state JUMP (11): pc_write=1, pc_source=10, then go to FETCH.
REQ-031 SHALL keep an 8-bit wait counter: cleared on entry to FETCH, MEMRD and MEMWR; incremented each cycle that mem_ready=0 in those states.
REQ-032 SHALL time out when the counter reaches MEM_TIMEOUT with mem_ready=0: set bus_err, force FETCH with the counter cleared, and assert no ir_write, pc_write or reg_we.
REQ-033 SHALL treat mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT as success; success SHALL take priority over timeout.
REQ-034 SHALL clear illegal_op and bus_err only on reset.
REQ-035 SHALL map encodings 12-15 to FETCH in the next cycle with no side effects.

Reset
REQ-036 SHALL, while rst=0, immediately force state=FETCH, counter=0, illegal_op=0, bus_err=0.
REQ-037 SHALL drive the FETCH output values from REQ-019 during reset, with ir_write=0 and pc_write=0.
REQ-038 SHALL, when reset is applied mid-instruction (e.g., in MEMWB), abort the instruction with no reg_we pulse after rst falls.

Structure
REQ-039 SHALL take state encodings, opcode constants, and the alu_op/alu_src_b/pc_source encodings from shared package mips_pkg.
REQ-040 SHALL have one natural sub-module, mips_mem_wait (wait counter plus timeout compare); the FSM SHALL remain in mips_mc_control.

Verification
REQ-041 SHALL cover R-type 000000 with mem_ready=1 -> states 0,1,6,7,0; reg_we=1 only in state 7 with reg_dst=1; 4 cycles.
REQ-042 SHALL cover lw 100011 with mem_ready delayed 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; reg_we with mem_to_reg=1 only in 4.
REQ-043 SHALL cover opcode 111111 -> DECODE to FETCH; illegal_op=1 and stays 1 until rst=0.
REQ-044 SHALL cover MEM_TIMEOUT=4, sw with mem_ready held 0 -> bus_err=1 after 4 MEMWR wait cycles, state=FETCH, no mem_write in the next cycle.
REQ-045 SHALL cover mem_ready=1 exactly on the timeout cycle -> bus_err stays 0 and the transition is normal.
REQ-046 SHALL cover rst falling asynchronously mid-cycle in ALUWB -> state_dbg=0 before the next clk edge, reg_we=0.
